// File: rtl/load_store_unit_if.sv
// Load/store unit bus: request handshake, response handshake, data-memory port.
// Ports: req_* / resp_* handshakes and mem_* doubleword memory signals.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_rdata;

  modport master (
    output req_valid, req_load, req_store,
    output req_funct3, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_load, req_store,
    input  req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err,
    output mem_addr, mem_wdata,
    output mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: sub-doubleword access to a 64-bit memory via read-modify-write.
// Ports: clk, reset (async active-low), bus (slave side of load_store_unit_if).
module load_store_unit #(
  parameter int unsigned MEM_BYTES   = 64,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, RD, WR, RESP
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rd_buf_q, rd_buf_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        load_q, load_d;
  logic        err_q, err_d;

  logic [2:0]  amask;
  logic        fault;
  logic [5:0]  lane_sh;
  logic [63:0] smask;
  logic [63:0] wmask;
  logic [63:0] shifted;
  logic [63:0] ld_val;
  logic [63:0] wr_data;

  // Low address bits that must be zero for the requested size.
  always_comb begin
    amask = 3'b000;
    unique case (bus.req_funct3[1:0])
      2'b00:   amask = 3'b000;
      2'b01:   amask = 3'b001;
      2'b10:   amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end

  always_comb begin
    fault = 1'b0;
    if (bus.req_load == bus.req_store)
      fault = 1'b1;
    if (bus.req_load && bus.req_funct3 == 3'b111)
      fault = 1'b1;
    if (bus.req_store && bus.req_funct3[2])
      fault = 1'b1;
    if (bus.req_addr >= 64'(MEM_BYTES))
      fault = 1'b1;
    if (CHECK_ALIGN && (bus.req_addr[2:0] & amask) != 3'b000)
      fault = 1'b1;
  end

  assign lane_sh = {addr_q[2:0], 3'b000};

  always_comb begin
    smask = '1;
    unique case (funct3_q[1:0])
      2'b00:   smask = 64'h0000_0000_0000_00FF;
      2'b01:   smask = 64'h0000_0000_0000_FFFF;
      2'b10:   smask = 64'h0000_0000_FFFF_FFFF;
      default: smask = '1;
    endcase
  end

  // Shifts drop bytes past lane 7, so unaligned overruns read as zero
  // and overrun store bytes are discarded.
  assign wmask   = smask << lane_sh;
  assign shifted = rd_buf_q >> lane_sh;

  always_comb begin
    wr_data = (rd_buf_q & ~wmask) | ((wdata_q & smask) << lane_sh);
    if (funct3_q[1:0] == 2'b11)
      wr_data = wdata_q;
  end

  always_comb begin
    ld_val = '0;
    unique case (funct3_q)
      3'b000:  ld_val = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_val = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_val = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  ld_val = shifted;
      3'b100:  ld_val = {56'd0, shifted[7:0]};
      3'b101:  ld_val = {48'd0, shifted[15:0]};
      3'b110:  ld_val = {32'd0, shifted[31:0]};
      default: ld_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_buf_d = rd_buf_q;
    funct3_d = funct3_q;
    load_d   = load_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          funct3_d = bus.req_funct3;
          load_d   = bus.req_load;
          err_d    = fault;
          if (fault)
            state_d = RESP;
          else if (bus.req_store && bus.req_funct3 == 3'b011)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        rd_buf_d = bus.mem_rdata;
        state_d  = load_q ? RESP : WR;
      end
      WR: state_d = RESP;
      default: begin
        if (bus.resp_ready)
          state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_buf_q <= '0;
      funct3_q <= '0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_buf_q <= rd_buf_d;
      funct3_q <= funct3_d;
      load_q   <= load_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from the state register so an async reset
  // drops mem_write immediately.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.mem_read   = (state_q == RD);
    bus.mem_write  = (state_q == WR);
    bus.resp_err   = (state_q == RESP) && err_q;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_rdata = '0;
    if (state_q == RD || state_q == WR)
      bus.mem_addr = {addr_q[63:3], 3'b000};
    if (state_q == WR)
      bus.mem_wdata = wr_data;
    if (state_q == RESP && load_q && !err_q)
      bus.resp_rdata = ld_val;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-array reference model.
// Ports: none; drives the unit through load_store_unit_if and models data memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [63:0] mem [8];
  logic [7:0]  ref_mem [64];

  load_store_unit_if bus ();

  load_store_unit #(
    .MEM_BYTES   (64),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[5:3]];

  always @(negedge clk)
    if (bus.mem_write)
      mem[bus.mem_addr[5:3]] <= bus.mem_wdata;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int k);
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++)
      d[8*i +: 8] = ref_mem[8*k + i];
    return d;
  endfunction

  task automatic model(input logic ld, input logic st,
                       input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er,
                       output int lat, output int nrd, output int nwr);
    int sz;
    int base;
    sz = 1 << f3[1:0];
    er = (ld == st) || (ld && f3 == 3'b111) || (st && f3[2])
      || (a >= 64) || (a % 64'(sz) != 0);
    rd = '0;
    nrd = 0;
    nwr = 0;
    if (er) begin
      lat = 1;
    end else begin
      base = int'(a);
      if (ld) begin
        for (int i = 0; i < sz; i++)
          rd[8*i +: 8] = ref_mem[base + i];
        if (!f3[2] && sz < 8 && rd[8*sz-1])
          for (int i = 8*sz; i < 64; i++)
            rd[i] = 1'b1;
        lat = 2;
        nrd = 1;
      end else begin
        for (int i = 0; i < sz; i++)
          ref_mem[base + i] = wd[8*i +: 8];
        lat = (sz == 8) ? 2 : 3;
        nrd = (sz == 8) ? 0 : 1;
        nwr = 1;
      end
    end
  endtask

  task automatic do_req(input logic ld, input logic st,
                        input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int hold,
                        output logic [63:0] rd, output logic er,
                        output int lat, output int nrd, output int nwr,
                        output logic [63:0] waddr);
    logic [63:0] rd0;
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_load   = ld;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    lat = 1;
    nrd = 0;
    nwr = 0;
    waddr = '0;
    while (!bus.resp_valid && lat < 8) begin
      if (bus.mem_read) nrd++;
      if (bus.mem_write) begin
        nwr++;
        waddr = bus.mem_addr;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.resp_valid)
      check("resp_timeout", 64'd0, 64'd1);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    rd0 = rd;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(bus.resp_valid), 64'd1);
      check("hold_rdata", bus.resp_rdata, rd0);
      check("hold_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic run(input logic ld, input logic st,
                     input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd,
                     input int hold, output logic [63:0] got);
    logic [63:0] erd, waddr;
    logic        eer, ger;
    int          elat, glat, enrd, gnrd, enwr, gnwr;
    model(ld, st, f3, a, wd, erd, eer, elat, enrd, enwr);
    do_req(ld, st, f3, a, wd, hold, got, ger, glat, gnrd, gnwr, waddr);
    check("rdata", got, erd);
    check("err", 64'(ger), 64'(eer));
    check("latency", 64'(glat), 64'(elat));
    check("n_read", 64'(gnrd), 64'(enrd));
    check("n_write", 64'(gnwr), 64'(enwr));
    if (enwr != 0) begin
      check("wr_addr", waddr, a & ~64'd7);
      check("mem_dword", mem[a[5:3]], ref_dword(int'(a[5:3])));
    end
  endtask

  logic [63:0] r;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_load   = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    #12;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata, 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_mem_read", 64'(bus.mem_read), 64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 1, 3'b011, 64'd8, 64'h1122334455667788, 0, r);
    check("sd_mem8", mem[1], 64'h1122334455667788);
    run(1, 0, 3'b000, 64'd8, 64'd0, 0, r);
    check("lb_8", r, 64'hFFFFFFFFFFFFFF88);
    run(1, 0, 3'b100, 64'd8, 64'd0, 0, r);
    check("lbu_8", r, 64'h88);
    run(1, 0, 3'b011, 64'd8, 64'd0, 0, r);
    check("ld_8", r, 64'h1122334455667788);
    run(0, 1, 3'b000, 64'd10, 64'hAB, 0, r);
    check("sb_mem8", mem[1], 64'h1122334455AB7788);
    run(1, 0, 3'b001, 64'd10, 64'd0, 0, r);
    check("lh_10", r, 64'h55AB);
    run(1, 0, 3'b010, 64'd6, 64'd0, 0, r);
    run(1, 0, 3'b011, 64'd64, 64'd0, 0, r);
    run(1, 1, 3'b000, 64'd0, 64'd0, 0, r);
    run(1, 0, 3'b111, 64'd0, 64'd0, 0, r);
    run(0, 1, 3'b100, 64'd0, 64'd0, 0, r);
    run(1, 0, 3'b011, 64'd8, 64'd0, 5, r);

    // Reset in the middle of a write cycle, before the commit edge.
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'd16;
    bus.req_wdata  = 64'hDEADBEEFCAFEF00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    check("wr_before_rst", 64'(bus.mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wr_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_wr_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_wr_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_wr_mem_addr", bus.mem_addr, 64'd0);
    check("rst_wr_mem_wdata", bus.mem_wdata, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_no_commit", mem[2], ref_dword(2));
    run(1, 0, 3'b011, 64'd16, 64'd0, 0, r);

    for (int n = 0; n < 150; n++) begin
      logic        ld, st;
      logic [2:0]  f3;
      logic [63:0] a, wd;
      int          sel;
      sel = $urandom_range(0, 9);
      ld = (sel >= 2 && sel <= 5) || sel == 1;
      st = sel >= 6 || sel == 1;
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        a = 64'($urandom_range(64, 200));
      else
        a = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0)
        a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      wd = {$urandom, $urandom};
      run(ld, st, f3, a, wd, $urandom_range(0, 2), r);
    end

    for (int k = 0; k < 8; k++)
      check("final_mem", mem[k], ref_dword(k));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
